// File: rtl/comb_filter_ctrl_if.sv
// Signal bundle between the comb-filter sequencer, its upstream/downstream
// sample streams and the clock-enabled comb filter it drives.
interface comb_filter_ctrl_if #(
  parameter int unsigned BIT_WIDTH = 16
) ();
  logic                 enable;
  logic                 cfg_strobe;
  logic                 cfg_bypass;
  logic                 in_strobe;
  logic [BIT_WIDTH-1:0] i_in;
  logic [BIT_WIDTH-1:0] q_in;
  logic                 filt_ce;
  logic                 filt_reset;
  logic [BIT_WIDTH-1:0] filt_i;
  logic [BIT_WIDTH-1:0] filt_q;
  logic [BIT_WIDTH-1:0] filt_i_out;
  logic [BIT_WIDTH-1:0] filt_q_out;
  logic                 out_strobe;
  logic [BIT_WIDTH-1:0] i_out;
  logic [BIT_WIDTH-1:0] q_out;
  logic [1:0]           state;
  logic                 dropped;

  modport master (
    output enable, cfg_strobe, cfg_bypass, in_strobe, i_in, q_in, filt_i_out, filt_q_out,
    input  filt_ce, filt_reset, filt_i, filt_q, out_strobe, i_out, q_out, state, dropped
  );

  modport slave (
    input  enable, cfg_strobe, cfg_bypass, in_strobe, i_in, q_in, filt_i_out, filt_q_out,
    output filt_ce, filt_reset, filt_i, filt_q, out_strobe, i_out, q_out, state, dropped
  );
endinterface

// File: rtl/comb_filter_ctrl.sv
// Sequencer for a clock-enabled I/Q comb filter: flushes its unreset history with
// zeros, discards settling samples, then streams output (or bypasses the filter).
module comb_filter_ctrl #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned FLUSH_LEN  = 1024,
  parameter int unsigned SETTLE_LEN = 16
) (
  input logic               clock,
  input logic               reset,
  comb_filter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFlush  = 2'd1,
    StSettle = 2'd2,
    StRun    = 2'd3
  } state_e;

  localparam logic [15:0] FlushLast  = 16'(FLUSH_LEN);
  localparam logic [15:0] SettleLast = 16'(SETTLE_LEN - 1);

  state_e      state_q, state_d;
  logic        bypass_q, bypass_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dropped_q, dropped_d;

  logic                 s1_valid_q, s1_bypass_q;
  logic [BIT_WIDTH-1:0] s1_i_q, s1_q_q;
  logic                 out_strobe_q;
  logic [BIT_WIDTH-1:0] i_out_q, q_out_q;

  logic                 filt_ce, filt_reset, accept;
  logic [BIT_WIDTH-1:0] filt_i, filt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      bypass_q  <= 1'b0;
      cnt_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bypass_q  <= bypass_d;
      cnt_q     <= cnt_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bypass_d = bus.cfg_strobe ? bus.cfg_bypass : bypass_q;
    if (!bus.enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (bus.cfg_strobe && state_q != StIdle) begin
      state_d = bus.cfg_bypass ? StRun : StFlush;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = bypass_q ? StRun : StFlush;
          cnt_d   = '0;
        end
        StFlush: begin
          // cnt_q == 0 is the filter-reset cycle; 1..FLUSH_LEN are zero-fill cycles
          if (cnt_q == FlushLast) begin
            state_d = StSettle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StSettle: begin
          if (bus.in_strobe) begin
            if (cnt_q == SettleLast) begin
              state_d = StRun;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        StRun: ;
        default: ;
      endcase
    end
  end

  // Set wins over the cfg_strobe clear
  always_comb begin
    dropped_d = dropped_q & ~bus.cfg_strobe;
    if (bus.enable && bus.in_strobe && (state_q == StIdle || state_q == StFlush)) begin
      dropped_d = 1'b1;
    end
  end

  always_comb begin
    filt_reset = 1'b0;
    filt_ce    = 1'b0;
    filt_i     = '0;
    filt_q     = '0;
    unique case (state_q)
      StFlush: begin
        filt_reset = (cnt_q == 16'd0);
        filt_ce    = (cnt_q != 16'd0);
      end
      StSettle, StRun: begin
        filt_i  = bus.i_in;
        filt_q  = bus.q_in;
        filt_ce = bus.in_strobe & ~bypass_q;
      end
      default: ;
    endcase
  end

  assign accept = (state_q == StRun) && bus.in_strobe;

  // Stage 1 waits for the filter output register; stage 2 picks filter or bypass data.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_bypass_q  <= 1'b0;
      s1_i_q       <= '0;
      s1_q_q       <= '0;
      out_strobe_q <= 1'b0;
      i_out_q      <= '0;
      q_out_q      <= '0;
    end else begin
      s1_valid_q   <= accept;
      out_strobe_q <= s1_valid_q;
      if (accept) begin
        s1_bypass_q <= bypass_q;
        s1_i_q      <= bus.i_in;
        s1_q_q      <= bus.q_in;
      end
      if (s1_valid_q) begin
        i_out_q <= s1_bypass_q ? s1_i_q : bus.filt_i_out;
        q_out_q <= s1_bypass_q ? s1_q_q : bus.filt_q_out;
      end
    end
  end

  assign bus.filt_ce    = filt_ce;
  assign bus.filt_reset = filt_reset;
  assign bus.filt_i     = filt_i;
  assign bus.filt_q     = filt_q;
  assign bus.out_strobe = out_strobe_q;
  assign bus.i_out      = i_out_q;
  assign bus.q_out      = q_out_q;
  assign bus.state      = state_q;
  assign bus.dropped    = dropped_q;

endmodule

// File: doc/comb_filter_ctrl.md
Name: comb_filter_ctrl

Overview:
- Sequencer for one strobed I/Q comb-filter instance in the sdr_lib receive chain. The filter is the clock-enabled variant: its state advances only when its enable is high, and its output register updates on that enabled edge.
- The filter's history memory has no reset in synthesis. This block clears it by driving zeros for a programmable number of cycles, then discards settling samples before emitting valid output.
- Also provides a bypass mode and a sticky indication of input samples dropped while the filter is not accepting data.

Parameters:
- BIT_WIDTH, 16, sample width of I and Q (two's complement).
- FLUSH_LEN, 1024, number of zero-input enabled cycles driven into the filter during FLUSH (1..65535).
- SETTLE_LEN, 16, number of accepted input samples discarded after FLUSH before output is valid (1..65535).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  run request; low forces IDLE.
- cfg_strobe  in  1  one-cycle configuration write; latches cfg_bypass and restarts sequencing.
- cfg_bypass  in  1  1 = pass input to output unfiltered.
- in_strobe  in  1  qualifies i_in/q_in.
- i_in  in  BIT_WIDTH  input I sample.
- q_in  in  BIT_WIDTH  input Q sample.
- filt_ce  out  1  filter clock enable.
- filt_reset  out  1  filter reset (counter and output register).
- filt_i  out  BIT_WIDTH  filter I input.
- filt_q  out  BIT_WIDTH  filter Q input.
- filt_i_out  in  BIT_WIDTH  filter I output.
- filt_q_out  in  BIT_WIDTH  filter Q output.
- out_strobe  out  1  qualifies i_out/q_out.
- i_out  out  BIT_WIDTH  output I sample.
- q_out  out  BIT_WIDTH  output Q sample.
- state  out  2  IDLE=0, FLUSH=1, SETTLE=2, RUN=3.
- dropped  out  1  sticky flag: an input sample was discarded.

Behaviour:
- Reset values: state IDLE; bypass register 0; counters 0; all outputs 0 (filt_ce, filt_reset, out_strobe, dropped, all data).
- filt_i/filt_q: equal i_in/q_in when state is SETTLE or RUN, 0 otherwise. Combinational from state and inputs.
- filt_ce: 1 every FLUSH cycle except the first; equals in_strobe in SETTLE and RUN (non-bypass); 0 in IDLE and in bypass.
- IDLE:
  - enable=1 and bypass=0 -> FLUSH.
  - enable=1 and bypass=1 -> RUN.
  - cfg_strobe in IDLE latches cfg_bypass; no other effect.
- FLUSH:
  - First cycle: filt_reset=1, filt_ce=0.
  - Then exactly FLUSH_LEN cycles with filt_ce=1 and zero input, counted by a 16-bit counter.
  - After the last of those cycles -> SETTLE. FLUSH therefore lasts 1+FLUSH_LEN cycles.
- SETTLE:
  - Each in_strobe is fed to the filter and counted.
  - The cycle of the SETTLE_LEN-th strobe is the last SETTLE cycle; next state is RUN.
  - No out_strobe is generated for settling samples.
- RUN:
  - Non-bypass: in_strobe at cycle t -> filt_ce at t -> out_strobe at t+2, with i_out/q_out = filt_i_out/filt_q_out registered at t+1.
  - Bypass: in_strobe at t -> out_strobe at t+2 with i_out/q_out = i_in/q_in from t, via two register stages. Latency is identical to non-bypass.
- enable=0 in any state: next state IDLE. Any in-flight output still completes its out_strobe; pipeline stages are not cleared.
- cfg_strobe in FLUSH, SETTLE or RUN:
  - Latches cfg_bypass.
  - Next state FLUSH if the new bypass=0 (counters cleared, flush restarts from its first cycle); RUN if bypass=1.
  - In-flight outputs complete.
- Simultaneous events:
  - enable=0 with cfg_strobe: IDLE wins, bypass still latched.
  - cfg_strobe with in_strobe in RUN: the sample is processed normally.
- dropped:
  - Set when in_strobe=1 in IDLE or FLUSH while enable=1. Strobes while enable=0 are ignored and do not set it.
  - Cleared only by reset or cfg_strobe. Set takes priority over clear in the same cycle.
- out_strobe pulses are one cycle wide; data holds its value between strobes.
- Counters saturate-free: parameter range guarantees no wrap.
- Implementation is two-stage registered with no combinational path from filt_*_out to outputs.

Test Plan:
- Bench overrides BIT_WIDTH=16, FLUSH_LEN=16, SETTLE_LEN=4.
- Reset, enable=1, cfg_bypass=0 -> one filt_reset cycle, then exactly 16 cycles filt_ce=1 with filt_i=filt_q=0, then state=2; out_strobe stays 0 throughout.
- In SETTLE, strobe samples 1,2,3,4 every 3rd cycle -> filt_ce mirrors each strobe, no out_strobe, state=3 after the 4th. Next strobe of i_in=0x0100 -> out_strobe exactly 2 cycles later carrying the filter model's output.
- Bypass: cfg_strobe with cfg_bypass=1 in RUN, then strobe i_in=0x1234, q_in=0xFEDC -> filt_ce=0; out_strobe 2 cycles later with i_out=0x1234, q_out=0xFEDC.
- Mid-operation cfg_strobe (cfg_bypass=0) during SETTLE after 2 samples -> state=1 next cycle, flush restarts (1+16 cycles), settle count restarts at 0.
- Strobe during FLUSH -> dropped=1 and stays set through RUN; cfg_strobe clears it. Strobe and cfg_strobe in the same FLUSH cycle -> dropped=1.
- enable dropped in RUN one cycle after a strobe -> state=0 next cycle; the pending out_strobe still appears; subsequent strobes produce no output and leave dropped=0.
